register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The module SHALL declare these parameters:
- DATA_W, 16, register width.
- NUM_REGS, 16, register count.
- LINK_REG, 15, index written by the link port.
REQ-002 The module SHALL have these ports:
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous active-low reset.
- ReadAddr1  input  16  port-1 register index; only bits [3:0] used.
- ReadAddr2  input  16  port-2 register index, driven by the RegSrc2 mux output; only bits [3:0] used.
- ReadData1  output  16  port-1 read value.
- ReadData2  output  16  port-2 read value.
- WriteAddr  input  4  primary write index.
- WriteData  input  16  primary write value.
- WriteEn  input  1  primary write request.
- LinkData  input  16  return address for the link write.
- LinkEn  input  1  link write request to LINK_REG.
- Stall  input  1  suppresses all writes this cycle.
- DbgAddr  input  4  debug read index.
- DbgData  output  16  debug read value, registered.
- WriteCount  output  16  count of committed writes.

Function
REQ-003 Register 0 SHALL read as 0 on every read port, and writes to it SHALL be discarded.
- A discarded write to register 0 SHALL NOT increment WriteCount.
REQ-004 Read ports 1 and 2 SHALL be combinational, with zero-cycle latency from the address.
REQ-005 Bits [15:4] of ReadAddr1/ReadAddr2 SHALL be ignored. Address 16'h0013 reads register 3.
REQ-006 Read-during-write bypass: when a write to index N commits on the coming edge, a read of N SHALL return the new value in the same cycle.
- If both write ports target N, the bypass SHALL return the winning value per REQ-008.
REQ-007 On a rising Clk edge with Stall=0, the register file SHALL apply writes as follows:
- If WriteEn=1, regs[WriteAddr] <= WriteData.
- If LinkEn=1, regs[LINK_REG] <= LinkData.
REQ-008 Simultaneous writes SHALL be resolved as follows:
- If WriteEn=1, LinkEn=1 and WriteAddr=LINK_REG, WriteData SHALL win.
- That collision SHALL count as one write.
REQ-009 With Stall=1, no register and no counter SHALL change, and the bypass SHALL be disabled.
REQ-010 WriteCount SHALL increment by the number of committed writes to non-zero indices per edge (0, 1 or 2).
- It SHALL wrap modulo 2^16 (16'hFFFF + 1 -> 16'h0000).
REQ-011 DbgData SHALL equal regs[DbgAddr] as sampled at the previous rising edge, giving one-cycle latency.
- DbgData SHALL NOT be bypassed.
- DbgAddr=0 SHALL give 0.
REQ-012 The design SHALL have no other state. It SHALL be a pure storage and forwarding block with no handshake.

Reset
REQ-013 Reset_n=0 SHALL asynchronously clear all registers, DbgData and WriteCount to 0, with no clock required.
REQ-014 Writes presented in the cycle in which Reset_n deasserts SHALL commit at the first rising edge where Reset_n=1 at the edge.
REQ-015 Reset asserted mid-cycle SHALL take precedence over any concurrent write.
- ReadData1/ReadData2 SHALL then show 0 combinationally unless the bypass is active.

Structure
REQ-016 DATA_W, NUM_REGS, LINK_REG and a reg_idx_t 4-bit index typedef SHALL live in the shared cpu package, which the decoder and the RegSrc2 mux also use.
REQ-017 The block SHALL be a single module with no sub-modules.
- The bypass/priority logic SHALL be a local function, reused for both read ports.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset then read all 16 indices -> all 0. Write 16'hBEEF to r0, then read r0 -> 0, and WriteCount stays 0.
- WriteEn=1, WriteAddr=5, WriteData=16'h1234, ReadAddr2=16'h0005 in the same cycle -> ReadData2=16'h1234 before the edge; after the edge it is still 16'h1234 and WriteCount=1.
- WriteEn=1, WriteAddr=15, WriteData=16'hAAAA with LinkEn=1, LinkData=16'h0042 -> r15=16'hAAAA and WriteCount increments by 1. With WriteAddr=3 instead -> r3=16'hAAAA, r15=16'h0042, and WriteCount increments by 2.
- Stall=1 with WriteEn=1, WriteAddr=2, WriteData=16'h7777 -> r2 unchanged, ReadData of r2 shows the old value, WriteCount unchanged.
- Preload WriteCount to 16'hFFFF via writes, then one more write -> 16'h0000. Set DbgAddr=4 after writing r4=16'h0F0F -> DbgData=16'h0F0F exactly one cycle later.
- Assert Reset_n low between edges after loading r7=16'h5555 -> r7, DbgData and WriteCount read 0 immediately, before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the register file, the decoder and the RegSrc2 mux.
// Holds the datapath width, register count, link register index and the register index type.
package cpu_pkg;

   localparam int DATA_W   = 16;
   localparam int NUM_REGS = 16;
   localparam int LINK_REG = 15;

   typedef logic [3:0] reg_idx_t;

endpackage

// File: rtl/register_file.sv
// Register file with two combinational read ports, a primary write port, a link write port,
// read-during-write bypass, a registered debug read port and a committed-write counter.
module register_file
   import cpu_pkg::reg_idx_t;
#(
   parameter int DATA_W   = cpu_pkg::DATA_W,
   parameter int NUM_REGS = cpu_pkg::NUM_REGS,
   parameter int LINK_REG = cpu_pkg::LINK_REG
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [15:0]       ReadAddr1,
   input  logic [15:0]       ReadAddr2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2,
   input  logic [3:0]        WriteAddr,
   input  logic [DATA_W-1:0] WriteData,
   input  logic              WriteEn,
   input  logic [DATA_W-1:0] LinkData,
   input  logic              LinkEn,
   input  logic              Stall,
   input  logic [3:0]        DbgAddr,
   output logic [DATA_W-1:0] DbgData,
   output logic [15:0]       WriteCount
);

   typedef logic [DATA_W-1:0] word_t;

   localparam reg_idx_t LINK_IDX = reg_idx_t'(LINK_REG);

   word_t    regs [NUM_REGS];
   reg_idx_t rd_idx1;
   reg_idx_t rd_idx2;
   logic     wr_main;
   logic     wr_link;
   logic [1:0] wr_num;
   logic     unused_addr_bits;

   assign rd_idx1 = ReadAddr1[3:0];
   assign rd_idx2 = ReadAddr2[3:0];
   assign unused_addr_bits = ^{ReadAddr1[15:4], ReadAddr2[15:4]};

   // Writes to r0 are dropped here so they neither commit nor count; on a collision at
   // the link register the primary port wins and the link write is suppressed.
   assign wr_main = WriteEn && !Stall && (WriteAddr != '0);
   assign wr_link = LinkEn && !Stall && (LINK_IDX != '0) &&
                    !(wr_main && (WriteAddr == LINK_IDX));
   assign wr_num  = {1'b0, wr_main} + {1'b0, wr_link};

   // Bypass/priority resolution shared by both read ports.
   function automatic word_t read_port(input reg_idx_t idx, input word_t stored,
                                       input logic main_en, input reg_idx_t main_idx,
                                       input word_t main_data, input logic link_en,
                                       input word_t link_data);
      word_t result;
      result = stored;
      if (idx == '0)
         result = '0;
      else if (main_en && (idx == main_idx))
         result = main_data;
      else if (link_en && (idx == LINK_IDX))
         result = link_data;
      return result;
   endfunction

   always_comb begin
      ReadData1 = read_port(rd_idx1, regs[rd_idx1], wr_main, WriteAddr, WriteData,
                            wr_link, LinkData);
      ReadData2 = read_port(rd_idx2, regs[rd_idx2], wr_main, WriteAddr, WriteData,
                            wr_link, LinkData);
   end

   // NOTE: the storage array is cleared by the async reset because r0..r15 must read 0
   // without a clock; all state here uses non-blocking assignments so reads see pre-edge values.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
         DbgData    <= '0;
         WriteCount <= '0;
      end else begin
         if (wr_main)
            regs[WriteAddr] <= WriteData;
         if (wr_link)
            regs[LINK_IDX] <= LinkData;
         WriteCount <= WriteCount + 16'(wr_num);
         DbgData    <= (DbgAddr == '0) ? '0 : regs[DbgAddr];
      end
   end

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, r0 masking, bypass, link collision,
// stall, counter wrap, debug latency and mid-cycle asynchronous reset.
module tb_register_file;

   logic        Clk;
   logic        Reset_n;
   logic [15:0] ReadAddr1;
   logic [15:0] ReadAddr2;
   logic [15:0] ReadData1;
   logic [15:0] ReadData2;
   logic [3:0]  WriteAddr;
   logic [15:0] WriteData;
   logic        WriteEn;
   logic [15:0] LinkData;
   logic        LinkEn;
   logic        Stall;
   logic [3:0]  DbgAddr;
   logic [15:0] DbgData;
   logic [15:0] WriteCount;

   int checks = 0;
   int errors = 0;

   register_file dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .ReadAddr1  (ReadAddr1),
      .ReadAddr2  (ReadAddr2),
      .ReadData1  (ReadData1),
      .ReadData2  (ReadData2),
      .WriteAddr  (WriteAddr),
      .WriteData  (WriteData),
      .WriteEn    (WriteEn),
      .LinkData   (LinkData),
      .LinkEn     (LinkEn),
      .Stall      (Stall),
      .DbgAddr    (DbgAddr),
      .DbgData    (DbgData),
      .WriteCount (WriteCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance past one rising edge and settle away from it.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset_n   = 1'b0;
      ReadAddr1 = '0;
      ReadAddr2 = '0;
      WriteAddr = '0;
      WriteData = '0;
      WriteEn   = 1'b0;
      LinkData  = '0;
      LinkEn    = 1'b0;
      Stall     = 1'b0;
      DbgAddr   = '0;
      #12;

      // Reset state: every index reads zero.
      for (int i = 0; i < 16; i++) begin
         ReadAddr1 = 16'(i);
         ReadAddr2 = 16'(15 - i);
         #1;
         check($sformatf("reset_rd1_r%0d", i), ReadData1, 16'h0000);
         check($sformatf("reset_rd2_r%0d", 15 - i), ReadData2, 16'h0000);
      end
      check("reset_dbg", DbgData, 16'h0000);
      check("reset_cnt", WriteCount, 16'h0000);

      @(negedge Clk);
      Reset_n = 1'b1;

      // Write to r0 is discarded and not counted.
      WriteEn = 1'b1; WriteAddr = 4'd0; WriteData = 16'hBEEF; ReadAddr1 = 16'h0000;
      #1;
      check("r0_bypass", ReadData1, 16'h0000);
      tick();
      WriteEn = 1'b0;
      #1;
      check("r0_after", ReadData1, 16'h0000);
      check("r0_cnt", WriteCount, 16'h0000);

      // Same-cycle bypass on port 2.
      WriteEn = 1'b1; WriteAddr = 4'd5; WriteData = 16'h1234; ReadAddr2 = 16'h0005;
      #1;
      check("r5_bypass", ReadData2, 16'h1234);
      tick();
      WriteEn = 1'b0;
      #1;
      check("r5_after", ReadData2, 16'h1234);
      check("r5_cnt", WriteCount, 16'h0001);
      ReadAddr1 = 16'h0015;
      #1;
      check("addr_hi_ignored", ReadData1, 16'h1234);

      // Collision at link register: primary wins, counted once.
      WriteEn = 1'b1; WriteAddr = 4'd15; WriteData = 16'hAAAA;
      LinkEn  = 1'b1; LinkData  = 16'h0042; ReadAddr1 = 16'h000F;
      #1;
      check("collide_bypass", ReadData1, 16'hAAAA);
      tick();
      WriteEn = 1'b0; LinkEn = 1'b0;
      #1;
      check("collide_r15", ReadData1, 16'hAAAA);
      check("collide_cnt", WriteCount, 16'h0002);

      // Independent primary and link writes count twice.
      WriteEn = 1'b1; WriteAddr = 4'd3; WriteData = 16'hAAAA;
      LinkEn  = 1'b1; LinkData  = 16'h0042; ReadAddr2 = 16'h000F;
      #1;
      check("link_bypass", ReadData2, 16'h0042);
      tick();
      WriteEn = 1'b0; LinkEn = 1'b0; ReadAddr1 = 16'h0003;
      #1;
      check("dual_r3", ReadData1, 16'hAAAA);
      check("dual_r15", ReadData2, 16'h0042);
      check("dual_cnt", WriteCount, 16'h0004);

      // Stall freezes registers, counter and bypass.
      WriteEn = 1'b1; WriteAddr = 4'd2; WriteData = 16'h1111;
      tick();
      Stall = 1'b1; WriteData = 16'h7777; ReadAddr1 = 16'h0002;
      #1;
      check("stall_no_bypass", ReadData1, 16'h1111);
      tick();
      check("stall_r2", ReadData1, 16'h1111);
      check("stall_cnt", WriteCount, 16'h0005);
      Stall = 1'b0; WriteEn = 1'b0;

      // Drive the counter to 16'hFFFF with two writes per cycle, then wrap it.
      WriteEn = 1'b1; WriteAddr = 4'd1; WriteData = 16'h0001;
      LinkEn  = 1'b1; LinkData  = 16'h0042;
      for (int i = 0; i < 32765; i++)
         tick();
      LinkEn = 1'b0;
      check("cnt_ffff", WriteCount, 16'hFFFF);
      WriteAddr = 4'd4; WriteData = 16'h0F0F;
      tick();
      WriteEn = 1'b0;
      check("cnt_wrap", WriteCount, 16'h0000);

      // Debug port: one-cycle latency and no bypass.
      DbgAddr = 4'd4;
      #1;
      check("dbg_latency", DbgData, 16'h0000);
      tick();
      check("dbg_r4", DbgData, 16'h0F0F);
      DbgAddr = 4'd6; WriteEn = 1'b1; WriteAddr = 4'd6; WriteData = 16'h6666;
      tick();
      WriteEn = 1'b0;
      check("dbg_no_bypass", DbgData, 16'h0000);
      tick();
      check("dbg_r6", DbgData, 16'h6666);
      DbgAddr = 4'd0;
      tick();
      check("dbg_r0", DbgData, 16'h0000);

      // Mid-cycle reset clears everything without a clock edge.
      WriteEn = 1'b1; WriteAddr = 4'd7; WriteData = 16'h5555;
      tick();
      WriteEn = 1'b0; DbgAddr = 4'd7;
      tick();
      check("pre_rst_dbg", DbgData, 16'h5555);
      ReadAddr1 = 16'h0007;
      @(negedge Clk);
      #1;
      Reset_n = 1'b0;
      WriteEn = 1'b1; WriteAddr = 4'd9; WriteData = 16'h9999; ReadAddr2 = 16'h0009;
      #1;
      check("rst_r7", ReadData1, 16'h0000);
      check("rst_dbg", DbgData, 16'h0000);
      check("rst_cnt", WriteCount, 16'h0000);
      check("rst_bypass", ReadData2, 16'h9999);

      // Write held across reset release commits at the first edge with reset high.
      tick();
      check("rst_hold_cnt", WriteCount, 16'h0000);
      @(negedge Clk);
      Reset_n = 1'b1;
      tick();
      WriteEn = 1'b0;
      #1;
      check("rel_r9", ReadData2, 16'h9999);
      check("rel_cnt", WriteCount, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
